// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: stall/flush/forwarding control from a shadow E/M/W scoreboard.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrD_i,
  input  logic                  RegWriteD_i,
  input  logic [1:0]            PCSrcE_i,
  input  logic                  MemReadyM_i,
  output logic                  PCen_o,
  output logic                  Fen_o,
  output logic                  Frst_o,
  output logic                  Den_o,
  output logic                  Drst_o,
  output logic                  MemStall_o,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic [PERF_WIDTH-1:0] StallCnt_o,
  output logic [PERF_WIDTH-1:0] FlushCnt_o
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]                opD;
  logic                      useRs1D, useRs2D, isLoadD, isMemD;
  logic [REG_ADDR_WIDTH-1:0] rs1D, rs2D, rdD;
  logic                      unusedInstrBits;

  assign opD     = InstrD_i[6:0];
  assign useRs1D = opD inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign useRs2D = opD inside {OP_REG, OP_STORE, OP_BRANCH};
  assign rs1D    = useRs1D ? InstrD_i[15 +: REG_ADDR_WIDTH] : '0;
  assign rs2D    = useRs2D ? InstrD_i[20 +: REG_ADDR_WIDTH] : '0;
  assign rdD     = InstrD_i[7 +: REG_ADDR_WIDTH];
  assign isLoadD = (opD == OP_LOAD);
  assign isMemD  = isLoadD | (opD == OP_STORE);
  assign unusedInstrBits = ^{InstrD_i[DATA_WIDTH-1:25], InstrD_i[14:12]};

  logic [REG_ADDR_WIDTH-1:0] rdE_q, rs1E_q, rs2E_q, rdM_q, rdW_q;
  logic                      regWriteE_q, isLoadE_q, isMemE_q;
  logic                      regWriteM_q, isMemM_q, regWriteW_q;
  logic [0:0]                state_q, state_d;

  logic memStall, redirect, loadUse;

  assign memStall = isMemM_q & ~MemReadyM_i;
  assign redirect = (PCSrcE_i != 2'b00);
  assign loadUse  = isLoadE_q & (rdE_q != '0) & ((rdE_q == rs1D) | (rdE_q == rs2D));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (memStall)    state_d = MEM_WAIT;
      MEM_WAIT: if (MemReadyM_i) state_d = RUN;
      default:                   state_d = RUN;
    endcase
  end

  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (regWriteM_q && (rdM_q != '0) && (rdM_q == rs)) return 2'b10;
    if (regWriteW_q && (rdW_q != '0) && (rdW_q == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Priority: reset, memory stall, redirect, load-use.
  always_comb begin
    PCen_o      = 1'b1;
    Fen_o       = 1'b1;
    Den_o       = 1'b1;
    Frst_o      = 1'b0;
    Drst_o      = 1'b0;
    MemStall_o  = 1'b0;
    ForwardAE_o = fwdSel(rs1E_q);
    ForwardBE_o = fwdSel(rs2E_q);
    if (rst) begin
      Frst_o      = 1'b1;
      Drst_o      = 1'b1;
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;
    end else if (memStall) begin
      PCen_o     = 1'b0;
      Fen_o      = 1'b0;
      Den_o      = 1'b0;
      MemStall_o = 1'b1;
    end else if (redirect) begin
      Frst_o = 1'b1;
      Drst_o = 1'b1;
    end else if (loadUse) begin
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Drst_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      rdE_q       <= '0;
      rs1E_q      <= '0;
      rs2E_q      <= '0;
      regWriteE_q <= 1'b0;
      isLoadE_q   <= 1'b0;
      isMemE_q    <= 1'b0;
      rdM_q       <= '0;
      regWriteM_q <= 1'b0;
      isMemM_q    <= 1'b0;
      rdW_q       <= '0;
      regWriteW_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!memStall) begin
        rdW_q       <= rdM_q;
        regWriteW_q <= regWriteM_q;
        rdM_q       <= rdE_q;
        regWriteM_q <= regWriteE_q;
        isMemM_q    <= isMemE_q;
        if (redirect || loadUse) begin
          rdE_q       <= '0;
          rs1E_q      <= '0;
          rs2E_q      <= '0;
          regWriteE_q <= 1'b0;
          isLoadE_q   <= 1'b0;
          isMemE_q    <= 1'b0;
        end else begin
          rdE_q       <= rdD;
          rs1E_q      <= rs1D;
          rs2E_q      <= rs2D;
          regWriteE_q <= RegWriteD_i;
          isLoadE_q   <= isLoadD;
          isMemE_q    <= isMemD;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0] stallCnt_q, flushCnt_q;
  logic [PERF_WIDTH-1:0] one;

  assign one = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (memStall || (!redirect && loadUse)) stallCnt_q <= stallCnt_q + one;
      if (!memStall && redirect)              flushCnt_q <= flushCnt_q + one;
    end
  end

  assign StallCnt_o = stallCnt_q;
  assign FlushCnt_o = flushCnt_q;
`else
  assign StallCnt_o = '0;
  assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard testbench for hazard_ctrl: directed instruction streams with hand-computed control/forward values.
// Counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Control nibble order: {PCen, Fen, Frst, Den, Drst, MemStall}
  localparam logic [5:0] NORM  = 6'b110100;
  localparam logic [5:0] LUSE  = 6'b000110;
  localparam logic [5:0] MSTL  = 6'b000001;
  localparam logic [5:0] REDIR = 6'b111110;
  localparam logic [5:0] RSTV  = 6'b111110;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        RegWriteD;
  logic [1:0]  PCSrcE;
  logic        MemReadyM;
  logic        PCen, Fen, Frst, Den, Drst, MemStall;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCnt, FlushCnt;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD_i    (InstrD),
    .RegWriteD_i (RegWriteD),
    .PCSrcE_i    (PCSrcE),
    .MemReadyM_i (MemReadyM),
    .PCen_o      (PCen),
    .Fen_o       (Fen),
    .Frst_o      (Frst),
    .Den_o       (Den),
    .Drst_o      (Drst),
    .MemStall_o  (MemStall),
    .ForwardAE_o (ForwardAE),
    .ForwardBE_o (ForwardBE),
    .StallCnt_o  (StallCnt),
    .FlushCnt_o  (FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] exp;
    logic       rstCycle;
  } expT;

  expT         sb[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] expStall = '0;
  logic [31:0] expFlush = '0;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] instr, input logic rw,
                               input logic [1:0] pcsrc, input logic ready, input logic rstv,
                               input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    expT e;
    @(posedge clk);
    #1;
    InstrD    = instr;
    RegWriteD = rw;
    PCSrcE    = pcsrc;
    MemReadyM = ready;
    rst       = rstv;
    e.name     = name;
    e.exp      = {ctl, fa, fb};
    e.rstCycle = rstv;
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so each queued expectation is consumed mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.name, {22'd0, PCen, Fen, Frst, Den, Drst, MemStall, ForwardAE, ForwardBE},
                    {22'd0, e.exp});
        checkOutput({e.name, ".stallCnt"}, StallCnt, expStall);
        checkOutput({e.name, ".flushCnt"}, FlushCnt, expFlush);
        if (e.rstCycle) begin
          expStall = '0;
          expFlush = '0;
        end else if (PERF) begin
          if (!e.exp[9]) expStall = expStall + 32'd1;
          if (e.exp[7])  expFlush = expFlush + 32'd1;
        end
      end
    end
  end

  initial begin
    logic [31:0] nop;
    nop       = enc(OP_IMM, 5'd0, 5'd0, 5'd0);
    rst       = 1'b1;
    InstrD    = nop;
    RegWriteD = 1'b1;
    PCSrcE    = 2'b00;
    MemReadyM = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus("reset",         nop,                            1'b1, 2'b00, 1'b1, 1'b1, RSTV, 2'b00, 2'b00);
    // lw x5,0(x1) then add x6,x5,x2
    applyStimulus("lw_issue",      enc(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("loaduse_stall", enc(OP_REG, 5'd6, 5'd5, 5'd2),  1'b1, 2'b00, 1'b1, 1'b0, LUSE, 2'b00, 2'b00);
    applyStimulus("loaduse_after", enc(OP_REG, 5'd6, 5'd5, 5'd2),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // The load has reached W by the time the add sits in E.
    applyStimulus("loaduse_fwd",   nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b01, 2'b00);
    // add x3,x1,x2 ; sub x4,x3,x3 ; and x7,x3,x1
    applyStimulus("add3_issue",    enc(OP_REG, 5'd3, 5'd1, 5'd2),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("sub4_issue",    enc(OP_REG, 5'd4, 5'd3, 5'd3),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("fwd_m_both",    enc(OP_REG, 5'd7, 5'd3, 5'd1),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b10, 2'b10);
    applyStimulus("fwd_w_a",       nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b01, 2'b00);
    // addi x9,x0,1 ; addi x9,x9,2 ; add x10,x9,x9
    applyStimulus("addi9_issue",   enc(OP_IMM, 5'd9, 5'd0, 5'd1),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("addi9b_issue",  enc(OP_IMM, 5'd9, 5'd9, 5'd2),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("fwd_m_chain",   enc(OP_REG, 5'd10, 5'd9, 5'd9), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b10, 2'b00);
    applyStimulus("fwd_m_beats_w", nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b10, 2'b10);
    applyStimulus("idle0",         nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // beq x1,x2 taken
    applyStimulus("beq_issue",     enc(OP_BRANCH, 5'd0, 5'd1, 5'd2), 1'b0, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("beq_redirect",  enc(OP_REG, 5'd11, 5'd1, 5'd1), 1'b1, 2'b01, 1'b1, 1'b0, REDIR, 2'b00, 2'b00);
    applyStimulus("redirect_done", nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // sw x5,0(x1) held in M for three cycles
    applyStimulus("sw_issue",      enc(OP_STORE, 5'd0, 5'd1, 5'd5), 1'b0, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("add12_issue",   enc(OP_REG, 5'd12, 5'd1, 5'd2), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++)
      applyStimulus("mem_stall",   enc(OP_REG, 5'd13, 5'd12, 5'd1), 1'b1, 2'b00, 1'b0, 1'b0, MSTL, 2'b00, 2'b00);
    applyStimulus("mem_release",   enc(OP_REG, 5'd13, 5'd12, 5'd1), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("held_fwd_m",    nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b10, 2'b00);
    applyStimulus("idle1",         nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // sw x1,4(x2) ; jalr x1,0(x5) redirecting while the store stalls
    applyStimulus("sw2_issue",     enc(OP_STORE, 5'd4, 5'd2, 5'd1), 1'b0, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("jalr_issue",    enc(OP_JALR, 5'd1, 5'd5, 5'd0), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++)
      applyStimulus("stall_over_redir", enc(OP_REG, 5'd14, 5'd1, 5'd1), 1'b1, 2'b10, 1'b0, 1'b0, MSTL, 2'b00, 2'b00);
    applyStimulus("redir_on_release", enc(OP_REG, 5'd14, 5'd1, 5'd1), 1'b1, 2'b10, 1'b1, 1'b0, REDIR, 2'b00, 2'b00);
    applyStimulus("after_redir",   nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // addi x0,x0,1 ; add x15,x0,x0
    applyStimulus("addi_x0",       enc(OP_IMM, 5'd0, 5'd0, 5'd1),  1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("x0_reader",     enc(OP_REG, 5'd15, 5'd0, 5'd0), 1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("x0_not_fwd",    nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    // sw x1,0(x2) then reset in the middle of its stall
    applyStimulus("sw3_issue",     enc(OP_STORE, 5'd0, 5'd2, 5'd1), 1'b0, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("sw3_in_e",      nop,                            1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("sw3_stall",     nop,                            1'b1, 2'b00, 1'b0, 1'b0, MSTL, 2'b00, 2'b00);
    applyStimulus("reset_mid_wait", nop,                           1'b1, 2'b00, 1'b0, 1'b1, RSTV, 2'b00, 2'b00);
    applyStimulus("post_reset_run", nop,                           1'b1, 2'b00, 1'b0, 1'b0, NORM, 2'b00, 2'b00);
    applyStimulus("post_reset_idle", nop,                          1'b1, 2'b00, 1'b1, 1'b0, NORM, 2'b00, 2'b00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
